fp32_sub_pipe: RTL
==================

Name: fp32_sub_pipe

Overview:
- Pipelined IEEE-754 single-precision subtractor: o_res = i_a - i_b.
- Implements the inverse operation of the FPU's combinational adder and shares its special-case conventions.
- Three-stage pipeline with a valid/ready handshake and backpressure.
- Sits beside the adder in the FPU datapath; results feed the FPU result mux or writeback.

Parameters:
- QNAN, 32'h7FC00000, canonical quiet-NaN pattern driven on any NaN result.
- GRS_W, 3, guard/round/sticky bits kept below the 24-bit mantissa through align and add.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_a  in  32  minuend (FP32)
- i_b  in  32  subtrahend (FP32)
- i_vld  in  1  operand valid
- i_rdy  out  1  block can accept operands this cycle
- o_res  out  32  difference (FP32)
- o_res_vld  out  1  result valid
- o_rdy  in  1  downstream accepts result
- overflow  out  1  finite operands produced ±inf; qualified by o_res_vld
- invalid  out  1  NaN operand, or inf - inf with equal signs; qualified by o_res_vld

Behaviour:
- Reset (async): all stage valids cleared; o_res = 0, o_res_vld = 0, overflow = 0, invalid = 0. In-flight operations are discarded with no partial output.
- Handshake:
  - Input transfer occurs when i_vld && i_rdy; output transfer when o_res_vld && o_rdy.
  - Stage k advances when stage k+1 is empty or advancing.
  - i_rdy = !s1_vld || s1_adv (combinational, no bubble).
  - Outputs hold stable while o_res_vld && !o_rdy.
- Latency: 3 cycles from input acceptance to o_res_vld with o_rdy high. Throughput is 1 result per cycle. Results stay in order.
- S1 (unpack/align):
  - Flip the sign of b.
  - Hidden bit is 1 for exp != 0; subnormals use exp 1 with hidden bit 0.
  - Swap so that operand A has the larger {exp, man}.
  - Right-shift the smaller mantissa by the exponent difference, carrying GRS bits. A shift of 26 or more leaves only the sticky bit.
  - Classify NaN, inf and zero.
- S2 (add/sub): 28-bit magnitude add if effective signs are equal, else subtract (smaller from larger). Result sign is the sign of the larger operand.
- S3 (normalize/round/pack):
  - Normalize with carry-out right shift or leading-zero left shift; left shift stops at exp 1 (subnormal result).
  - Round to nearest, ties to even.
  - A post-round mantissa carry increments the exponent.
  - Exponent reaching 255 → ±inf (7F800000/FF800000) with overflow = 1.
- Special cases (priority order):
  - Any NaN → QNAN, invalid = 1.
  - +inf - +inf or -inf - -inf → QNAN, invalid = 1.
  - a inf → a.
  - b inf → b with sign flipped. overflow = 0 for propagated infinities.
  - Exact zero difference of nonzero operands → +0.
  - Both operands zero: result sign = a.sign AND NOT b.sign, so -0 - +0 = -0 and all other combinations give +0.
- Simultaneous input accept and output accept in a full pipeline: all stages shift; no loss, no duplication.

Optional Feature:
- Macro: FP_SUB_FTZ_EN.
- Defined:
  - Subnormal inputs are treated as same-signed zero in S1.
  - Subnormal results are flushed to signed zero in S3.
- Undefined: full gradual underflow as described in Behaviour.

Decomposition:
- Package fp32_pkg holds:
  - fp32 struct typedef {sign, exp[7:0], man[22:0]};
  - EXP_MAX = 8'hFF;
  - QNAN_C;
  - a class enum {NORM, SUBN, ZERO, INF, NAN}.
- One natural sub-module, fp32_lzc28: 28-bit leading-zero counter used by the S3 normalizer.

Test Plan:
- 40400000 - 3F800000 (3.0 - 1.0) → 40000000 exactly 3 cycles after acceptance; o_res_vld high 1 cycle with o_rdy = 1.
- 3F800000 - 3F800000 → 00000000; 80000000 - 00000000 → 80000000; 00000000 - 00000000 → 00000000.
- 7F800000 - 7F800000 → 7FC00000, invalid = 1; 3F800000 - FF800000 → 7F800000, overflow = 0; 7FC00001 - 0 → 7FC00000, invalid = 1.
- 7F7FFFFF - FF7FFFFF → 7F800000, overflow = 1. Rounding checks:
  - 3F800000 - 32800000 → 3F800000 (RNE discard);
  - 3F800001 - 33800000 → 3F800000 (tie to even).
- 00800000 - 00400000 → 00400000 without FP_SUB_FTZ_EN; → 00800000 with FP_SUB_FTZ_EN.
- Backpressure: issue 5 back-to-back ops with o_rdy low for 6 cycles → i_rdy drops after 3 accepts, o_res held stable, all 5 results emerge in order with none lost. Assert rst mid-stream → o_res_vld = 0 immediately, o_res = 0, and no stale results after release.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 types, constants and operand classification for the FPU datapath.
package fp32_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN_C  = 32'h7FC0_0000;

    typedef enum logic [2:0] {NORM, SUBN, ZERO, INF, NAN} fp_class_e;

    function automatic fp_class_e fp_classify(input fp32_t x);
        fp_class_e c;
        if (x.exp == EXP_MAX)
            c = (x.man != '0) ? NAN : INF;
        else if (x.exp == '0)
            c = (x.man != '0) ? SUBN : ZERO;
        else
            c = NORM;
        return c;
    endfunction

endpackage

// File: rtl/fp32_lzc28.sv
// Leading-zero counter for the subtractor normalizer; an all-zero input returns W.
module fp32_lzc28 #(
    parameter int unsigned W  = 28,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    always_comb begin
        cnt = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp32_sub_pipe.sv
// Three-stage pipelined FP32 subtractor (o_res = i_a - i_b) with valid/ready handshake.
// Define FP_SUB_FTZ_EN to flush subnormal inputs and results to signed zero.
module fp32_sub_pipe
    import fp32_pkg::*;
#(
    parameter logic [31:0] QNAN  = QNAN_C,
    parameter int unsigned GRS_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_vld,
    output logic        i_rdy,
    output logic [31:0] o_res,
    output logic        o_res_vld,
    input  logic        o_rdy,
    output logic        overflow,
    output logic        invalid
);

    localparam int unsigned MW = 24 + GRS_W;
    localparam int unsigned SW = MW + 1;
    localparam int unsigned CW = $clog2(SW + 1);

    typedef struct packed {
        logic          spec;
        logic [31:0]   spec_res;
        logic          spec_inv;
        logic          sign;
        logic          eff_sub;
        logic [7:0]    exp;
        logic [MW-1:0] man_l;
        logic [MW-1:0] man_s;
    } s1_t;

    typedef struct packed {
        logic          spec;
        logic [31:0]   spec_res;
        logic          spec_inv;
        logic          sign;
        logic [7:0]    exp;
        logic [SW-1:0] sum;
    } s2_t;

    logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    s1_t         s1_q, s1_d, s1_calc;
    s2_t         s2_q, s2_d, s2_calc;
    logic [31:0] res_q, res_d, res_calc;
    logic        ovf_q, ovf_d, ovf_calc;
    logic        inv_q, inv_d;
    logic        s1_adv, s2_adv, s3_adv, in_acc;

    assign s3_adv = s3_vld_q && o_rdy;
    assign s2_adv = s2_vld_q && (!s3_vld_q || s3_adv);
    assign s1_adv = s1_vld_q && (!s2_vld_q || s2_adv);
    assign i_rdy  = !s1_vld_q || s1_adv;
    assign in_acc = i_vld && i_rdy;

    // S1: unpack, swap larger magnitude into L, align S, classify specials
    fp32_t         a, b, l, s;
    fp_class_e     ca, cb;
    logic          a_big;
    logic [7:0]    el, es, ed;
    logic [23:0]   ml, ms;
    logic [MW-1:0] ms_ext, lost_mask;

    always_comb begin
        a = i_a;
        b = i_b;
        b.sign = ~i_b[31];
`ifdef FP_SUB_FTZ_EN
        if (a.exp == '0) a.man = '0;
        if (b.exp == '0) b.man = '0;
`endif
        ca = fp_classify(a);
        cb = fp_classify(b);
        a_big = {a.exp, a.man} >= {b.exp, b.man};
        l = a_big ? a : b;
        s = a_big ? b : a;
        el = (l.exp == '0) ? 8'd1 : l.exp;
        es = (s.exp == '0) ? 8'd1 : s.exp;
        ed = el - es;
        ml = {|l.exp, l.man};
        ms = {|s.exp, s.man};
        ms_ext = {ms, {GRS_W{1'b0}}};
        lost_mask = ~({MW{1'b1}} << ed);

        s1_calc = '0;
        s1_calc.sign = l.sign;
        s1_calc.eff_sub = l.sign ^ s.sign;
        s1_calc.exp = el;
        s1_calc.man_l = {ml, {GRS_W{1'b0}}};
        if (ed >= 8'(MW - 1)) begin
            s1_calc.man_s = {{(MW-1){1'b0}}, |ms};
        end else begin
            s1_calc.man_s = ms_ext >> ed;
            s1_calc.man_s[0] = s1_calc.man_s[0] | (|(ms_ext & lost_mask));
        end

        // b already carries its flipped sign, so inf - inf is invalid when signs now differ
        if (ca == NAN || cb == NAN) begin
            s1_calc.spec = 1'b1; s1_calc.spec_res = QNAN; s1_calc.spec_inv = 1'b1;
        end else if (ca == INF && cb == INF && a.sign != b.sign) begin
            s1_calc.spec = 1'b1; s1_calc.spec_res = QNAN; s1_calc.spec_inv = 1'b1;
        end else if (ca == INF) begin
            s1_calc.spec = 1'b1; s1_calc.spec_res = a;
        end else if (cb == INF) begin
            s1_calc.spec = 1'b1; s1_calc.spec_res = b;
        end else if (ca == ZERO && cb == ZERO) begin
            s1_calc.spec = 1'b1; s1_calc.spec_res = {a.sign & b.sign, 31'b0};
        end

        s1_vld_d = in_acc || (s1_vld_q && !s1_adv);
        s1_d = in_acc ? s1_calc : s1_q;
    end

    // S2: magnitude add or subtract (L >= S, so the difference is never negative)
    always_comb begin
        s2_calc.spec = s1_q.spec;
        s2_calc.spec_res = s1_q.spec_res;
        s2_calc.spec_inv = s1_q.spec_inv;
        s2_calc.sign = s1_q.sign;
        s2_calc.exp = s1_q.exp;
        if (s1_q.eff_sub)
            s2_calc.sum = {1'b0, s1_q.man_l} - {1'b0, s1_q.man_s};
        else
            s2_calc.sum = {1'b0, s1_q.man_l} + {1'b0, s1_q.man_s};

        s2_vld_d = s1_adv || (s2_vld_q && !s2_adv);
        s2_d = s1_adv ? s2_calc : s2_q;
    end

    // S3: normalize, round to nearest even, pack
    logic [CW-1:0] lz;
    logic [9:0]    e, sh, e_f;
    logic [MW-1:0] m;
    logic [23:0]   mant;
    logic          rnd;
    logic [24:0]   mr;
    logic [22:0]   frac;

    fp32_lzc28 #(.W(SW), .CW(CW)) u_lzc (.din(s2_q.sum), .cnt(lz));

    always_comb begin
        e = {2'b0, s2_q.exp};
        sh = '0;
        if (s2_q.sum[SW-1]) begin
            m = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
            e = e + 10'd1;
        end else begin
            // left shift is clamped so the exponent bottoms out at 1 (subnormal)
            sh = 10'(lz) - 10'd1;
            if (sh > e - 10'd1) sh = e - 10'd1;
            m = s2_q.sum[MW-1:0] << sh;
            e = e - sh;
        end
        mant = m[MW-1:GRS_W];
        rnd = m[GRS_W-1] & ((|m[GRS_W-2:0]) | m[GRS_W]);
        mr = {1'b0, mant} + {24'b0, rnd};
        if (mr[24]) begin
            e_f = e + 10'd1;
            frac = mr[23:1];
        end else begin
            e_f = mr[23] ? e : '0;
            frac = mr[22:0];
        end

        ovf_calc = 1'b0;
        if (s2_q.spec)
            res_calc = s2_q.spec_res;
        else if (s2_q.sum == '0)
            res_calc = '0;
        else if (e_f >= 10'd255) begin
            res_calc = {s2_q.sign, EXP_MAX, 23'b0};
            ovf_calc = 1'b1;
        end
`ifdef FP_SUB_FTZ_EN
        else if (e_f == '0)
            res_calc = {s2_q.sign, 31'b0};
`endif
        else
            res_calc = {s2_q.sign, e_f[7:0], frac};

        s3_vld_d = s2_adv || (s3_vld_q && !s3_adv);
        res_d = s2_adv ? res_calc : res_q;
        ovf_d = s2_adv ? ovf_calc : ovf_q;
        inv_d = s2_adv ? s2_q.spec_inv : inv_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s3_vld_q <= s3_vld_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    assign o_res     = res_q;
    assign o_res_vld = s3_vld_q;
    assign overflow  = ovf_q;
    assign invalid   = inv_q;

endmodule
